// File: rtl/ni_rx_pkg.sv
// ni_rx_pkg: packet format shared by the transmitting and receiving NIs.
// Item layout, MSB first: {parity, header[HDR_SZ-2:0], payload[PL_SZ], dest[ADDR_SZ]}.
// The parity bit makes the XOR of the whole item zero.
package ni_rx_pkg;

    localparam int unsigned ADDR_SZ = 4;
    localparam int unsigned PL_SZ   = 16;
    localparam int unsigned HDR_SZ  = 4;

    localparam int unsigned ITEM_W  = HDR_SZ + PL_SZ + ADDR_SZ;
    localparam int unsigned OUT_W   = HDR_SZ - 1 + PL_SZ;

    localparam int unsigned DEST_LSB = 0;
    localparam int unsigned PL_LSB   = ADDR_SZ;
    localparam int unsigned HDR_LSB  = ADDR_SZ + PL_SZ;
    localparam int unsigned PAR_BIT  = ITEM_W - 1;

    // Even parity over the full item, parity bit included.
    function automatic logic parity_good(input logic [ITEM_W-1:0] item);
        return ~(^item);
    endfunction

endpackage

// File: rtl/ni_rx_fifo.sv
// ni_rx_fifo: synchronous show-ahead FIFO.
// Ports: clk/reset (sync, active-high); push/din write; pop consumes the head;
// dout is the head (holds the last head, or 0 after reset, while empty);
// full/empty/count report occupancy. push while full is taken only with a pop.
module ni_rx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [WIDTH-1:0] hold;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? hold : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset && do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            hold   <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            // Track the head so the output stays put once the FIFO drains.
            if (!empty) hold <= mem[rd_ptr];
        end
    end

endmodule

// File: rtl/ni_rx.sv
// ni_rx: receive-side network interface.
// Classifies each valid item (parity, destination, overflow), runs the payload
// sequence check, buffers accepted {header, payload} in a show-ahead FIFO.
// Ports: clk, reset (sync, active-high); id node address; item_in/valid from
// the channel; busy registered backpressure; out_data/out_valid/out_ready to
// the local consumer; clear_err clears the sticky parity_err/seq_err/ovf_err;
// error is their registered OR; led toggles per accepted payload == TG_COUNT;
// rx_count/drop_count are saturating accepted/discarded counters.
module ni_rx
    import ni_rx_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TG_COUNT   = 500,
    parameter int unsigned CNT_W      = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_SZ-1:0] id,
    input  logic [ITEM_W-1:0]  item_in,
    input  logic               valid,
    output logic               busy,
    output logic [OUT_W-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    input  logic               clear_err,
    output logic               parity_err,
    output logic               seq_err,
    output logic               ovf_err,
    output logic               error,
    output logic               led,
    output logic [CNT_W-1:0]   rx_count,
    output logic [CNT_W-1:0]   drop_count
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [PL_SZ-1:0]    payload;
    logic [HDR_SZ-2:0]   header;
    logic                dest_ok;
    logic                par_ok;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CW-1:0]       occ;
    logic [CW-1:0]       occ_next;
    logic                pop;
    logic                accept;
    logic                drop;
    logic                par_ev;
    logic                ovf_ev;
    logic                seq_ev;
    logic                armed;
    logic [PL_SZ-1:0]    last;
    logic [PL_SZ-1:0]    expected;
    logic                pe_next;
    logic                se_next;
    logic                oe_next;

    assign payload  = item_in[PL_LSB +: PL_SZ];
    assign header   = item_in[HDR_LSB +: HDR_SZ-1];
    assign dest_ok  = (item_in[DEST_LSB +: ADDR_SZ] == id);
    assign par_ok   = parity_good(item_in);

    assign out_valid = ~fifo_empty;
    assign pop       = out_valid & out_ready;

    // Priority: parity, then destination, then overflow. A same-cycle pop
    // frees a slot, so a full FIFO still accepts.
    assign par_ev = valid & ~par_ok;
    assign accept = valid & par_ok & dest_ok & (~fifo_full | pop);
    assign ovf_ev = valid & par_ok & dest_ok & fifo_full & ~pop;
    assign drop   = valid & ~accept;

    assign expected = (last == PL_SZ'(TG_COUNT)) ? '0 : last + PL_SZ'(1);
    assign seq_ev   = accept & armed & (payload != expected);

    // An event in the clearing cycle keeps its flag set.
    assign pe_next = (parity_err & ~clear_err) | par_ev;
    assign se_next = (seq_err    & ~clear_err) | seq_ev;
    assign oe_next = (ovf_err    & ~clear_err) | ovf_ev;

    always_comb begin
        occ_next = occ;
        case ({accept, pop})
            2'b10:   occ_next = occ + CW'(1);
            2'b01:   occ_next = occ - CW'(1);
            default: occ_next = occ;
        endcase
    end

    ni_rx_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .pop   (pop),
        .din   ({header, payload}),
        .dout  (out_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (occ)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            busy       <= 1'b0;
            parity_err <= 1'b0;
            seq_err    <= 1'b0;
            ovf_err    <= 1'b0;
            error      <= 1'b0;
            led        <= 1'b0;
            rx_count   <= '0;
            drop_count <= '0;
            armed      <= 1'b0;
            last       <= '0;
        end else begin
            // One slot of headroom covers the item already in flight.
            busy       <= (occ_next >= CW'(FIFO_DEPTH - 1));
            parity_err <= pe_next;
            seq_err    <= se_next;
            ovf_err    <= oe_next;
            error      <= pe_next | se_next | oe_next;
            if (accept) begin
                armed <= 1'b1;
                last  <= payload;
                if (payload == PL_SZ'(TG_COUNT)) led <= ~led;
                if (rx_count != '1) rx_count <= rx_count + CNT_W'(1);
            end
            if (drop && drop_count != '1) begin
                drop_count <= drop_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ni_rx.sv
// tb_ni_rx: directed test-plan scenarios plus a randomized phase, all checked
// against a queue-based reference model of the receive NI.
module tb_ni_rx;
    import ni_rx_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TG    = 20;
    localparam int unsigned CW    = 6;
    localparam int          MAXC  = (1 << CW) - 1;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [ADDR_SZ-1:0] id = '0;
    logic [ITEM_W-1:0]  item_in = '0;
    logic               valid = 1'b0;
    logic               busy;
    logic [OUT_W-1:0]   out_data;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic               clear_err = 1'b0;
    logic               parity_err, seq_err, ovf_err, error, led;
    logic [CW-1:0]      rx_count, drop_count;

    ni_rx #(
        .FIFO_DEPTH (DEPTH),
        .TG_COUNT   (TG),
        .CNT_W      (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .id         (id),
        .item_in    (item_in),
        .valid      (valid),
        .busy       (busy),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .clear_err  (clear_err),
        .parity_err (parity_err),
        .seq_err    (seq_err),
        .ovf_err    (ovf_err),
        .error      (error),
        .led        (led),
        .rx_count   (rx_count),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    logic [OUT_W-1:0] q[$];
    logic [OUT_W-1:0] m_hold = '0;
    bit   m_pe, m_se, m_oe, m_led, m_busy, m_armed;
    int   m_rx, m_drop, m_last;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v > MAXC) ? MAXC : v;
    endfunction

    function automatic logic [ITEM_W-1:0] mk(input logic [ADDR_SZ-1:0] d,
                                             input logic [PL_SZ-1:0] p,
                                             input logic [HDR_SZ-2:0] h,
                                             input bit flip);
        logic [ITEM_W-1:0] r;
        r = {1'b0, h, p, d};
        if ($countones(r) % 2 == 1) r[ITEM_W-1] = 1'b1;
        if (flip) r[ADDR_SZ] = ~r[ADDR_SZ];
        return r;
    endfunction

    // Advance the model over the current inputs, clock the DUT, compare.
    task automatic step();
        int pl, exp_pl;
        bit pop, room;
        pl = int'(item_in[ADDR_SZ +: PL_SZ]);
        if (reset) begin
            q.delete();
            m_hold = '0;
            {m_pe, m_se, m_oe, m_led, m_busy, m_armed} = '0;
            m_rx = 0; m_drop = 0; m_last = 0;
        end else begin
            pop  = out_ready && (q.size() != 0);
            room = (q.size() < DEPTH) || pop;
            if (clear_err) {m_pe, m_se, m_oe} = '0;
            if (pop) m_hold = q.pop_front();
            if (valid) begin
                if ($countones(item_in) % 2 != 0) begin
                    m_pe = 1; m_drop++;
                end else if (item_in[ADDR_SZ-1:0] != id) begin
                    m_drop++;
                end else if (!room) begin
                    m_oe = 1; m_drop++;
                end else begin
                    q.push_back(item_in[ADDR_SZ +: OUT_W]);
                    m_rx++;
                    exp_pl = (m_last == TG) ? 0 : m_last + 1;
                    if (m_armed && pl != exp_pl) m_se = 1;
                    m_armed = 1;
                    m_last  = pl;
                    if (pl == TG) m_led = ~m_led;
                end
            end
            m_busy = (q.size() >= DEPTH - 1);
        end
        @(posedge clk);
        #1;
        check("busy",       32'(busy),       32'(m_busy));
        check("out_valid",  32'(out_valid),  32'(q.size() != 0));
        check("out_data",   32'(out_data),   32'((q.size() != 0) ? q[0] : m_hold));
        check("parity_err", 32'(parity_err), 32'(m_pe));
        check("seq_err",    32'(seq_err),    32'(m_se));
        check("ovf_err",    32'(ovf_err),    32'(m_oe));
        check("error",      32'(error),      32'(m_pe | m_se | m_oe));
        check("led",        32'(led),        32'(m_led));
        check("rx_count",   32'(rx_count),   32'(sat(m_rx)));
        check("drop_count", 32'(drop_count), 32'(sat(m_drop)));
    endtask

    task automatic send(input logic [ADDR_SZ-1:0] d, input int p, input bit flip);
        valid   = 1'b1;
        item_in = mk(d, PL_SZ'(p), (HDR_SZ-1)'($urandom), flip);
        step();
        valid   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        int nxt;
        logic [ADDR_SZ-1:0] d;
        logic [PL_SZ-1:0]   pl;

        id = 4'd1;
        reset = 1'b1;
        idle(2);
        reset = 1'b0;

        // In-order stream.
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) send(4'd1, i, 1'b0);
        idle(2);
        check("stream_rx", 32'(rx_count), 32'd10);
        check("stream_err", 32'(error), 32'd0);

        // Parity failure, then clear.
        send(4'd1, 10, 1'b1);
        check("par_flag", 32'(parity_err), 32'd1);
        check("par_drop", 32'(drop_count), 32'd1);
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        step();
        check("par_clr", 32'(error), 32'd0);

        // Sequence wrap and a deliberate gap.
        do_reset();
        send(4'd1, TG - 1, 1'b0);
        send(4'd1, TG, 1'b0);
        send(4'd1, 0, 1'b0);
        send(4'd1, 1, 1'b0);
        check("wrap_seq", 32'(seq_err), 32'd0);
        check("wrap_led", 32'(led), 32'd1);
        send(4'd1, 5, 1'b0);
        check("gap_seq", 32'(seq_err), 32'd1);
        idle(2);

        // Backpressure and overflow.
        out_ready = 1'b0;
        send(4'd1, 6, 1'b0);
        send(4'd1, 7, 1'b0);
        send(4'd1, 8, 1'b0);
        check("bp_busy3", 32'(busy), 32'd1);
        send(4'd1, 9, 1'b0);
        send(4'd1, 10, 1'b0);
        check("bp_ovf", 32'(ovf_err), 32'd1);
        out_ready = 1'b1;
        idle(6);
        check("bp_drain", 32'(busy), 32'd0);

        // Misroute, then reset with entries queued and a valid in the reset cycle.
        do_reset();
        send(4'd0, 0, 1'b0);
        check("mis_drop", 32'(drop_count), 32'd1);
        check("mis_seq", 32'(seq_err), 32'd0);
        out_ready = 1'b0;
        send(4'd1, 0, 1'b0);
        send(4'd1, 1, 1'b0);
        valid   = 1'b1;
        item_in = mk(4'd1, PL_SZ'(2), '0, 1'b0);
        do_reset();
        valid   = 1'b0;
        check("rst_ovalid", 32'(out_valid), 32'd0);
        check("rst_rx", 32'(rx_count), 32'd0);
        check("rst_led", 32'(led), 32'd0);

        // Randomized traffic; sender mostly honours busy and mostly sends in order.
        nxt = 0;
        for (int i = 0; i < 1500; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            if (reset) id = ADDR_SZ'($urandom);
            out_ready = ($urandom_range(0, 9) < 6);
            clear_err = ($urandom_range(0, 39) == 0);
            valid     = busy ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 9) < 7);
            d  = ($urandom_range(0, 9) == 0) ? ADDR_SZ'(id + 1) : id;
            pl = ($urandom_range(0, 9) < 8) ? PL_SZ'(nxt) : PL_SZ'($urandom_range(0, TG));
            item_in = mk(d, pl, (HDR_SZ-1)'($urandom), ($urandom_range(0, 19) == 0));
            if (valid) nxt = (int'(pl) == TG) ? 0 : int'(pl) + 1;
            step();
        end
        reset = 1'b0;
        valid = 1'b0;
        clear_err = 1'b0;
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
